// File: rtl/branch_ctrl.sv
// branch_ctrl: branch sequencer for the vasm core.
// Holds the architectural flags {C,Z,N,O}, accepts one branch at a time from
// decode, evaluates its condition against the registered flags and, for a
// taken branch, issues a one-cycle PC redirect plus a FLUSH_CYCLES-long flush.
// Optional feature: define BRANCH_STATS_EN to add saturating taken/not-taken
// counters with a synchronous clear (stats_clr).
module branch_ctrl #(
  parameter int PC_W         = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flags_we,
  input  logic            alu_c,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic            alu_o,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [3:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic [3:0]      flags_q,
  output logic            resolved,
  output logic            taken,
  output logic            illegal_cond,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
`ifdef BRANCH_STATS_EN
  input  logic            stats_clr,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     not_taken_cnt,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cond_q;
  logic [3:0]  cnt_q;
  logic        resolved_q, taken_q, illegal_q;
  logic        cond_taken, cond_illegal;
  logic        accept;

  assign accept = br_valid && (state_q == IDLE);

  // Flag register: loads from the ALU whenever flags_we is set, in any state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else if (flags_we) flags_q <= {alu_c, alu_z, alu_n, alu_o};
  end

  // Condition evaluation on the latched code and the registered flags.
  // NOTE: defaults assigned first so no path through the case leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (cond_q)
      4'b0000: cond_taken = flags_q[2];
      4'b0001: cond_taken = !flags_q[2];
      4'b0010: cond_taken = !flags_q[2] && (flags_q[1] == flags_q[0]);
      4'b0011: cond_taken = (flags_q[1] == flags_q[0]);
      4'b0100: cond_taken = (flags_q[1] != flags_q[0]);
      4'b0101: cond_taken = flags_q[2] || (flags_q[1] != flags_q[0]);
      4'b0110: cond_taken = flags_q[3];
      4'b0111: cond_taken = !flags_q[3];
      4'b1000: cond_taken = flags_q[0];
      4'b1001: cond_taken = !flags_q[0];
      4'b1010: cond_taken = flags_q[1];
      4'b1011: cond_taken = !flags_q[1];
      4'b1100: cond_taken = 1'b1;
      default: cond_illegal = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> EVAL on accept, EVAL -> FLUSH when taken,
  // FLUSH returns to IDLE after the last flush cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EVAL;
      EVAL:    state_d = cond_taken ? FLUSH : IDLE;
      FLUSH:   if (cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; redirect only in the first flush cycle.
  always_comb begin
    br_ready       = (state_q == IDLE);
    busy           = (state_q != IDLE);
    flush          = (state_q == FLUSH);
    redirect_valid = (state_q == FLUSH) && (cnt_q == FLUSH_LOAD);
  end

  // Branch capture at acceptance and flush-length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q      <= 4'b0000;
      redirect_pc <= '0;
      cnt_q       <= 4'd0;
    end else begin
      if (accept) begin
        cond_q      <= br_cond;
        redirect_pc <= br_target;
      end
      if (state_q == EVAL && cond_taken) cnt_q <= FLUSH_LOAD;
      else if (state_q == FLUSH)         cnt_q <= cnt_q - 4'd1;
    end
  end

  // Registered decision: pulses land in the cycle after EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resolved_q <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      resolved_q <= (state_q == EVAL);
      taken_q    <= (state_q == EVAL) && cond_taken;
      illegal_q  <= (state_q == EVAL) && cond_illegal;
    end
  end

  assign resolved     = resolved_q;
  assign taken        = taken_q;
  assign illegal_cond = illegal_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, not_taken_cnt_q;

  // Saturating outcome counters; a clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q     <= 16'd0;
      not_taken_cnt_q <= 16'd0;
    end else if (stats_clr) begin
      taken_cnt_q     <= 16'd0;
      not_taken_cnt_q <= 16'd0;
    end else if (resolved_q) begin
      if (taken_q && taken_cnt_q != 16'hFFFF)
        taken_cnt_q <= taken_cnt_q + 16'd1;
      if (!taken_q && not_taken_cnt_q != 16'hFFFF)
        not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule
